// File: rtl/run_monitor.sv
// run_monitor: run controller and halt detector for the Computer.
//
// A run is requested with a one-cycle start pulse while idle. The CPU is held
// in reset for RESET_CYCLES cycles and then released. While it runs, the
// block counts cycles and watches the program counter. The run ends in one
// of two ways:
//   - halted:  the PC has stayed unchanged for STABLE_CYCLES consecutive cycles
//   - timeout: the run has lasted MAX_CYCLES cycles
// When the run ends, the CPU is frozen again and the final PC and one probed
// RAM word are captured. Both stay readable until the next start.
//
// Ports:
//   clk         system clock; all state changes on the rising edge
//   reset       synchronous, active-low reset
//   start       one-cycle run request; honoured only in IDLE
//   clear       acknowledges a finished run; DONE_* -> IDLE
//   pc          CPU program counter, sampled every cycle
//   ram_word    probed RAM word, captured when the run ends
//   cpu_reset   active-high reset to the CPU (high except in RUN)
//   busy        high in RESET_HOLD or RUN
//   done        high in DONE_HALT or DONE_TIMEOUT
//   halted      high in DONE_HALT
//   timeout     high in DONE_TIMEOUT
//   cycle_count RUN cycles elapsed in the current or last run
//   halt_pc     PC captured when the run ended
//   result      ram_word captured when the run ended
module run_monitor #(
  parameter int PC_WIDTH      = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int CNT_WIDTH     = 32,
  parameter int MAX_CYCLES    = 1000,
  parameter int STABLE_CYCLES = 1,
  parameter int RESET_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0] ram_word,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  halted,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [PC_WIDTH-1:0]   halt_pc,
  output logic [DATA_WIDTH-1:0] result
);

  // Reject parameter sets under which the counters could wrap
  if ((MAX_CYCLES < 1) || (STABLE_CYCLES < 1) || (RESET_CYCLES < 1)) begin : g_bad_limits
    $error("run_monitor: MAX_CYCLES, STABLE_CYCLES and RESET_CYCLES must be >= 1");
  end
  if ((CNT_WIDTH < 63) && (64'(MAX_CYCLES) >= (64'd1 << CNT_WIDTH))) begin : g_bad_width
    $error("run_monitor: CNT_WIDTH too narrow to hold MAX_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLD      = 3'd1,
    S_RUN       = 3'd2,
    S_DONE_HALT = 3'd3,
    S_DONE_TO   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [CNT_WIDTH-1:0]  cycle_count_r;
  logic [CNT_WIDTH-1:0]  hold_cnt_r;
  logic [CNT_WIDTH-1:0]  stable_cnt_r;
  logic [PC_WIDTH-1:0]   prev_pc_r;
  logic                  prev_valid_r;
  logic [PC_WIDTH-1:0]   halt_pc_r;
  logic [DATA_WIDTH-1:0] result_r;

  logic [CNT_WIDTH-1:0]  cnt_inc_s;
  logic                  match_s;
  logic [CNT_WIDTH-1:0]  stable_next_s;

  // Run-progress terms shared by the next-state logic and the datapath.
  // prev_valid masks the stale prev_pc so the first RUN cycle never matches.
  always_comb begin
    cnt_inc_s     = cycle_count_r + CNT_WIDTH'(1);
    match_s       = prev_valid_r && (pc == prev_pc_r);
    stable_next_s = match_s ? (stable_cnt_r + CNT_WIDTH'(1)) : {CNT_WIDTH{1'b0}};
  end

  // Next-state logic; halt is tested before timeout so it wins a tie
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_HOLD;
        else       state_s = S_IDLE;
      end
      S_HOLD: begin
        if (hold_cnt_r == {CNT_WIDTH{1'b0}}) state_s = S_RUN;
        else                                 state_s = S_HOLD;
      end
      S_RUN: begin
        if (stable_next_s == CNT_WIDTH'(STABLE_CYCLES))  state_s = S_DONE_HALT;
        else if (cnt_inc_s == CNT_WIDTH'(MAX_CYCLES))     state_s = S_DONE_TO;
        else                                              state_s = S_RUN;
      end
      S_DONE_HALT, S_DONE_TO: begin
        if (clear) state_s = S_IDLE;
        else       state_s = state_r;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Counters, PC history and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count_r <= {CNT_WIDTH{1'b0}};
      hold_cnt_r    <= {CNT_WIDTH{1'b0}};
      stable_cnt_r  <= {CNT_WIDTH{1'b0}};
      prev_pc_r     <= {PC_WIDTH{1'b0}};
      prev_valid_r  <= 1'b0;
      halt_pc_r     <= {PC_WIDTH{1'b0}};
      result_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cycle_count_r <= {CNT_WIDTH{1'b0}};
            prev_valid_r  <= 1'b0;
            stable_cnt_r  <= {CNT_WIDTH{1'b0}};
            hold_cnt_r    <= CNT_WIDTH'(RESET_CYCLES - 1);
          end
        end
        S_HOLD: begin
          if (hold_cnt_r != {CNT_WIDTH{1'b0}}) hold_cnt_r <= hold_cnt_r - CNT_WIDTH'(1);
        end
        S_RUN: begin
          cycle_count_r <= cnt_inc_s;
          prev_pc_r     <= pc;
          prev_valid_r  <= 1'b1;
          stable_cnt_r  <= stable_next_s;
          // Capture on the edge that leaves RUN
          if ((state_s == S_DONE_HALT) || (state_s == S_DONE_TO)) begin
            halt_pc_r <= pc;
            result_r  <= ram_word;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs are pure decodes of the state register
  assign cpu_reset   = (state_r != S_RUN);
  assign busy        = (state_r == S_HOLD) || (state_r == S_RUN);
  assign done        = (state_r == S_DONE_HALT) || (state_r == S_DONE_TO);
  assign halted      = (state_r == S_DONE_HALT);
  assign timeout     = (state_r == S_DONE_TO);
  assign cycle_count = cycle_count_r;
  assign halt_pc     = halt_pc_r;
  assign result      = result_r;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: three instances (defaults, MAX_CYCLES=5,
// STABLE_CYCLES=3 with RESET_CYCLES=2) are checked every cycle against a
// run-level model that keeps the whole PC history of each run.
module tb_run_monitor;

  localparam int N = 3;
  localparam int PH_IDLE = 0, PH_HOLD = 1, PH_RUN = 2, PH_HALT = 3, PH_TO = 4;

  int MAXC [N] = '{1000, 5, 1000};
  int STAB [N] = '{1, 1, 3};
  int RSTC [N] = '{1, 1, 2};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_v [N];
  logic        clear_v [N];
  logic [15:0] pc_v [N];
  logic [15:0] ram_word = 16'd42;

  logic        cpu_reset_o [N];
  logic        busy_o [N];
  logic        done_o [N];
  logic        halted_o [N];
  logic        timeout_o [N];
  logic [31:0] cc_o [N];
  logic [15:0] hpc_o [N];
  logic [15:0] res_o [N];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state
  int          ph [N];
  int          hold [N];
  int          cnt [N];
  int          hlen [N];
  logic [15:0] hist [N][0:1023];
  logic [15:0] m_hpc [N];
  logic [15:0] m_res [N];

  logic [15:0] seq [0:15];
  int          seq_len;

  run_monitor #(.MAX_CYCLES(1000)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .clear(clear_v[0]), .pc(pc_v[0]),
    .ram_word(ram_word), .cpu_reset(cpu_reset_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .halted(halted_o[0]), .timeout(timeout_o[0]), .cycle_count(cc_o[0]),
    .halt_pc(hpc_o[0]), .result(res_o[0]));

  run_monitor #(.MAX_CYCLES(5)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .clear(clear_v[1]), .pc(pc_v[1]),
    .ram_word(ram_word), .cpu_reset(cpu_reset_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .halted(halted_o[1]), .timeout(timeout_o[1]), .cycle_count(cc_o[1]),
    .halt_pc(hpc_o[1]), .result(res_o[1]));

  run_monitor #(.STABLE_CYCLES(3), .RESET_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .clear(clear_v[2]), .pc(pc_v[2]),
    .ram_word(ram_word), .cpu_reset(cpu_reset_o[2]), .busy(busy_o[2]), .done(done_o[2]),
    .halted(halted_o[2]), .timeout(timeout_o[2]), .cycle_count(cc_o[2]),
    .halt_pc(hpc_o[2]), .result(res_o[2]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // the last STABLE+1 PCs of the run are all equal
  function automatic bit pc_settled(input int i);
    if (hlen[i] < STAB[i] + 1) return 1'b0;
    for (int j = 1; j <= STAB[i]; j++)
      if (hist[i][hlen[i] - 1 - j] != hist[i][hlen[i] - 1]) return 1'b0;
    return 1'b1;
  endfunction

  // run-level model, advanced on every rising edge
  initial begin
    for (int i = 0; i < N; i++) begin
      ph[i] = PH_IDLE; hold[i] = 0; cnt[i] = 0; hlen[i] = 0;
      m_hpc[i] = 16'd0; m_res[i] = 16'd0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        if (!reset) begin
          ph[i] = PH_IDLE; hold[i] = 0; cnt[i] = 0; hlen[i] = 0;
          m_hpc[i] = 16'd0; m_res[i] = 16'd0;
        end else begin
          case (ph[i])
            PH_IDLE: if (start_v[i]) begin
              ph[i] = PH_HOLD; hold[i] = RSTC[i]; cnt[i] = 0; hlen[i] = 0;
            end
            PH_HOLD: begin
              hold[i] = hold[i] - 1;
              if (hold[i] == 0) ph[i] = PH_RUN;
            end
            PH_RUN: begin
              hist[i][hlen[i]] = pc_v[i];
              hlen[i] = hlen[i] + 1;
              cnt[i] = cnt[i] + 1;
              if (pc_settled(i)) begin
                ph[i] = PH_HALT; m_hpc[i] = pc_v[i]; m_res[i] = ram_word;
              end else if (cnt[i] == MAXC[i]) begin
                ph[i] = PH_TO; m_hpc[i] = pc_v[i]; m_res[i] = ram_word;
              end
            end
            PH_HALT, PH_TO: if (clear_v[i]) ph[i] = PH_IDLE;
            default: ;
          endcase
        end
      end
    end
  end

  // every-cycle comparison of all instances against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d cpu_reset", i), 64'(cpu_reset_o[i]), 64'(ph[i] != PH_RUN));
        chk($sformatf("u%0d busy", i), 64'(busy_o[i]), 64'(ph[i] == PH_HOLD || ph[i] == PH_RUN));
        chk($sformatf("u%0d done", i), 64'(done_o[i]), 64'(ph[i] == PH_HALT || ph[i] == PH_TO));
        chk($sformatf("u%0d halted", i), 64'(halted_o[i]), 64'(ph[i] == PH_HALT));
        chk($sformatf("u%0d timeout", i), 64'(timeout_o[i]), 64'(ph[i] == PH_TO));
        chk($sformatf("u%0d cycle_count", i), 64'(cc_o[i]), 64'(cnt[i]));
        chk($sformatf("u%0d halt_pc", i), 64'(hpc_o[i]), 64'(m_hpc[i]));
        chk($sformatf("u%0d result", i), 64'(res_o[i]), 64'(m_res[i]));
      end
    end
  end

  task automatic pulse_start(input int i);
    @(posedge clk); #2;
    start_v[i] = 1'b1;
    @(posedge clk); #2;
    start_v[i] = 1'b0;
  endtask

  task automatic pulse_clear(input int i);
    @(posedge clk); #2;
    clear_v[i] = 1'b1;
    @(posedge clk); #2;
    clear_v[i] = 1'b0;
  endtask

  // Drive one PC per RUN cycle (from seq, or k when incr) until the model
  // reports DONE, or until limit PCs were applied when limit > 0.
  task automatic feed(input int i, input int limit, input bit incr, input bit hs);
    int  k = 0;
    bit  fin = 1'b0;
    for (int it = 0; it < 1200; it++) begin
      if (ph[i] == PH_HALT || ph[i] == PH_TO) begin fin = 1'b1; break; end
      if (limit > 0 && k >= limit) break;
      start_v[i] = 1'b0;
      clear_v[i] = 1'b0;
      if (ph[i] == PH_RUN) begin
        pc_v[i] = incr ? 16'(k) : seq[(k < seq_len) ? k : seq_len - 1];
        if (hs && k == 1) begin start_v[i] = 1'b1; clear_v[i] = 1'b1; end
        k++;
      end
      @(posedge clk); #2;
    end
    start_v[i] = 1'b0;
    clear_v[i] = 1'b0;
    if (limit == 0 && !fin) chk($sformatf("u%0d run finished in budget", i), 64'd0, 64'd1);
  endtask

  task automatic set_seq5(input logic [15:0] a, b, c, d, e);
    seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d; seq[4] = e; seq_len = 5;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      start_v[i] = 1'b0; clear_v[i] = 1'b0; pc_v[i] = 16'd0;
    end
    seq_len = 1; seq[0] = 16'd0;

    // reset
    @(posedge clk); #2; reset = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2; reset = 1'b1;
    chk_en = 1'b1;
    chk("reset cpu_reset", 64'(cpu_reset_o[0]), 64'd1);
    chk("reset cycle_count", 64'(cc_o[0]), 64'd0);

    // basic halt on defaults: 0,1,2,3,3
    set_seq5(16'd0, 16'd1, 16'd2, 16'd3, 16'd3);
    pulse_start(0);
    feed(0, 0, 1'b0, 1'b0);
    chk("basic halted", 64'(halted_o[0]), 64'd1);
    chk("basic cycle_count", 64'(cc_o[0]), 64'd5);
    chk("basic halt_pc", 64'(hpc_o[0]), 64'd3);
    chk("basic result", 64'(res_o[0]), 64'd42);
    pulse_clear(0);

    // halt beats timeout when both hit (MAX_CYCLES=5)
    ram_word = 16'd77;
    pulse_start(1);
    feed(1, 0, 1'b0, 1'b0);
    chk("prio halted", 64'(halted_o[1]), 64'd1);
    chk("prio timeout", 64'(timeout_o[1]), 64'd0);
    chk("prio cycle_count", 64'(cc_o[1]), 64'd5);
    chk("prio result", 64'(res_o[1]), 64'd77);

    // STABLE=3, RESET=2: 0,1,1,2,2,2,2
    seq[0] = 16'd0; seq[1] = 16'd1; seq[2] = 16'd1; seq[3] = 16'd2;
    seq[4] = 16'd2; seq[5] = 16'd2; seq[6] = 16'd2; seq_len = 7;
    pulse_start(2);
    chk("hold cycle1 cpu_reset", 64'(cpu_reset_o[2]), 64'd1);
    @(posedge clk); #2;
    chk("hold cycle2 cpu_reset", 64'(cpu_reset_o[2]), 64'd1);
    @(posedge clk); #2;
    chk("hold released cpu_reset", 64'(cpu_reset_o[2]), 64'd0);
    feed(2, 0, 1'b0, 1'b0);
    chk("stable3 halted", 64'(halted_o[2]), 64'd1);
    chk("stable3 cycle_count", 64'(cc_o[2]), 64'd7);
    chk("stable3 halt_pc", 64'(hpc_o[2]), 64'd2);

    // handshake: start/clear in RUN ignored, clear in DONE, rerun
    ram_word = 16'd42;
    seq[0] = 16'd5; seq[1] = 16'd6; seq[2] = 16'd7; seq[3] = 16'd7; seq_len = 4;
    pulse_start(0);
    feed(0, 0, 1'b0, 1'b1);
    chk("hs halted", 64'(halted_o[0]), 64'd1);
    chk("hs cycle_count", 64'(cc_o[0]), 64'd4);
    pulse_clear(0);
    chk("hs done after clear", 64'(done_o[0]), 64'd0);
    chk("hs count retained", 64'(cc_o[0]), 64'd4);
    chk("hs halt_pc retained", 64'(hpc_o[0]), 64'd7);
    pulse_start(0);
    chk("hs restart clears count", 64'(cc_o[0]), 64'd0);
    feed(0, 0, 1'b0, 1'b0);
    chk("hs rerun cycle_count", 64'(cc_o[0]), 64'd4);
    pulse_clear(0);

    // timeout on defaults: pc increments every cycle
    ram_word = 16'd9;
    pulse_start(0);
    feed(0, 0, 1'b1, 1'b0);
    chk("to timeout", 64'(timeout_o[0]), 64'd1);
    chk("to halted", 64'(halted_o[0]), 64'd0);
    chk("to cycle_count", 64'(cc_o[0]), 64'd1000);
    chk("to halt_pc", 64'(hpc_o[0]), 64'd999);
    repeat (3) @(posedge clk);
    #2;
    chk("to cpu_reset held", 64'(cpu_reset_o[0]), 64'd1);
    pulse_clear(0);

    // reset in the third RUN cycle
    ram_word = 16'd42;
    pulse_start(0);
    feed(0, 3, 1'b1, 1'b0);
    chk("mid count before reset", 64'(cc_o[0]), 64'd3);
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    chk("mid cpu_reset", 64'(cpu_reset_o[0]), 64'd1);
    chk("mid busy", 64'(busy_o[0]), 64'd0);
    chk("mid cycle_count", 64'(cc_o[0]), 64'd0);
    chk("mid result", 64'(res_o[0]), 64'd0);
    repeat (2) @(posedge clk);
    #2;

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesisable run controller and halt detector for the Computer.
- Holds the CPU in reset for a programmable number of cycles, then releases it.
- Counts executed cycles and declares "halted" once PC stays unchanged for STABLE_CYCLES consecutive cycles, or "timeout" at MAX_CYCLES.
- Captures the final PC and one probed RAM word for readback by an on-chip host or a bench.

Parameters:
PC_WIDTH, 16, width of the observed program counter
DATA_WIDTH, 16, width of the probed RAM word
CNT_WIDTH, 32, width of the cycle counter; must hold MAX_CYCLES
MAX_CYCLES, 1000, safety limit on RUN cycles; must be >=1
STABLE_CYCLES, 1, consecutive unchanged-PC cycles that constitute a halt; must be >=1
RESET_CYCLES, 1, cycles cpu_reset is asserted after start; must be >=1

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low: reset==0 at a rising edge resets the block
start  input  1  one-cycle request to begin a run; honoured only in IDLE
clear  input  1  acknowledge result; DONE_* -> IDLE
pc  input  PC_WIDTH  CPU program counter, sampled every cycle
ram_word  input  DATA_WIDTH  probed RAM location, e.g. RAM[0]
cpu_reset  output  1  active-high reset to the Computer
busy  output  1  high in RESET_HOLD or RUN
done  output  1  high in DONE_HALT or DONE_TIMEOUT
halted  output  1  high in DONE_HALT
timeout  output  1  high in DONE_TIMEOUT
cycle_count  output  CNT_WIDTH  RUN cycles elapsed in the current or last run
halt_pc  output  PC_WIDTH  PC captured on entry to a DONE state
result  output  DATA_WIDTH  ram_word captured on entry to a DONE state

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - cpu_reset=1; the CPU is held in reset while idle.
  - busy=done=halted=timeout=0.
  - cycle_count=0, halt_pc=0, result=0.
  - Internal prev_pc=0, prev_valid=0, stable_cnt=0, hold_cnt=0.
  - Reset overrides everything, including mid-run; no result is retained.
- IDLE:
  - cpu_reset=1.
  - On start=1: go to RESET_HOLD; clear cycle_count, prev_valid, stable_cnt; set hold_cnt=RESET_CYCLES-1.
  - clear is ignored.
- RESET_HOLD:
  - cpu_reset=1, busy=1.
  - If hold_cnt==0: go to RUN. Otherwise decrement hold_cnt.
  - cpu_reset is high for exactly RESET_CYCLES cycles after the start edge.
- RUN: cpu_reset=0, busy=1. On each edge:
  - cycle_count <= cycle_count+1.
  - prev_pc <= pc; prev_valid <= 1.
  - match = prev_valid && (pc==prev_pc). The first RUN cycle never matches.
  - stable_next = match ? stable_cnt+1 : 0; stable_cnt <= stable_next.
  - If stable_next==STABLE_CYCLES: go to DONE_HALT.
  - Else if cycle_count+1==MAX_CYCLES: go to DONE_TIMEOUT.
  - Halt has priority when both conditions hit in the same cycle.
  - On entry to either DONE state: halt_pc <= pc; result <= ram_word; cycle_count holds the incremented value.
- DONE_HALT / DONE_TIMEOUT:
  - cpu_reset=1, which freezes the CPU.
  - done=1; halted or timeout accordingly.
  - Outputs are held stable.
  - clear=1: go to IDLE; flags drop the next cycle; cycle_count, halt_pc and result are retained until the next start.
  - start is ignored.
- start and clear are ignored in RESET_HOLD and RUN; there is no abort except reset.
- start and clear both high in IDLE: start wins.
- Counters never wrap: run length is bounded by MAX_CYCLES. Elaboration fails if MAX_CYCLES >= 2**CNT_WIDTH.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Test Plan:
- Basic halt (defaults):
  - Stimulus: after start, pc sequence in RUN is 0,1,2,3,3.
  - Required: halted=1, done=1 one edge after the second 3 is sampled; cycle_count=5; halt_pc=3; result=ram_word at that edge (drive 42 -> result=42).
- Timeout (defaults):
  - Stimulus: pc increments every cycle.
  - Required: timeout=1, halted=0, cycle_count=1000; cpu_reset=1 thereafter.
- Priority, MAX_CYCLES=5:
  - Stimulus: pc 0,1,2,3,3.
  - Required: DONE_HALT, not timeout; cycle_count=5.
- STABLE_CYCLES=3, RESET_CYCLES=2:
  - Stimulus: cpu_reset high for exactly 2 cycles after start; then pc 0,1,1,2,2,2,2.
  - Required: the 1,1 pair does not halt; halt occurs after the 4th consecutive 2; cycle_count=7; halt_pc=2.
- Handshake:
  - Stimulus: pulse start during RUN; pulse clear in RUN; then clear in DONE; then start again.
  - Required: start and clear in RUN have no effect; clear in DONE returns to IDLE with done=0 and cycle_count retained; the second start clears cycle_count and runs identically.
- Reset mid-run:
  - Stimulus: reset=0 at cycle 3 of RUN.
  - Required: next edge shows IDLE, cpu_reset=1, busy=0, cycle_count=0, result=0.
